// File: rtl/bp_share_scheduler.sv
// Two-requester round-robin front end for a single basic_branch_predictor.
// Sequences the predictor's lazy (one-step-delayed) outcome update and keeps per-requester accuracy counters.
module bp_share_scheduler #(
  parameter int IP_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [IP_W-1:0]  req_ip0,
  input  logic [IP_W-1:0]  req_ip1,
  input  logic             req_taken0,
  input  logic             req_taken1,
  input  logic             halt,
  output logic             pred_step,
  output logic [IP_W-1:0]  pred_ip,
  output logic             pred_taken,
  input  logic             pred_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_pred,
  output logic             rsp_mispredict,
  input  logic [1:0]       stat_sel,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_data
);

  // Handshake: record i is taken on a cycle where req_valid[i] & req_ready[i];
  // req_ready never looks at itself and is all-zero while halt is high.

  logic             rr_q, rr_d;
  logic             pend_taken_q, pend_taken_d;
  logic             step_q, step_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             accept;
  logic             grant_id;
  logic             grant_taken;
  logic [1:0]       lk_idx;
  logic [1:0]       mp_idx;

  always_comb begin
    accept   = 1'b0;
    grant_id = rr_q;
    if (!halt) begin
      if (req_valid[rr_q]) begin
        accept   = 1'b1;
        grant_id = rr_q;
      end else if (req_valid[~rr_q]) begin
        accept   = 1'b1;
        grant_id = ~rr_q;
      end
    end
  end

  assign req_ready   = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign grant_taken = grant_id ? req_taken1 : req_taken0;

  // The outcome handed to the predictor belongs to the previously stepped branch,
  // whichever requester owned it.
  assign pred_step  = accept;
  assign pred_ip    = accept ? (grant_id ? req_ip1 : req_ip0) : '0;
  assign pred_taken = accept & pend_taken_q;

  // pend_taken_q still holds this response's outcome even if a new step happens this cycle.
  assign rsp_valid      = step_q;
  assign rsp_id         = step_q & id_q;
  assign rsp_pred       = step_q & pred_out;
  assign rsp_mispredict = step_q & (pred_out ^ pend_taken_q);

  assign lk_idx    = {id_q, 1'b0};
  assign mp_idx    = {id_q, 1'b1};
  assign stat_data = cnt_q[stat_sel];

  always_comb begin
    rr_d         = rr_q;
    pend_taken_d = pend_taken_q;
    id_d         = id_q;
    step_d       = accept;
    if (accept) begin
      rr_d         = ~grant_id;
      pend_taken_d = grant_taken;
      id_d         = grant_id;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr) begin
        cnt_d[i] = '0;
      end else if (step_q && (cnt_q[i] != {CNT_W{1'b1}}) &&
                   ((2'(i) == lk_idx) || ((2'(i) == mp_idx) && rsp_mispredict))) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q         <= 1'b0;
      pend_taken_q <= 1'b0;
      step_q       <= 1'b0;
      id_q         <= 1'b0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      rr_q         <= rr_d;
      pend_taken_q <= pend_taken_d;
      step_q       <= step_d;
      id_q         <= id_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
